// File: rtl/divider_pkg.sv
// Shared types and helpers for the restoring shift-subtract divider.
// Optional packed-BCD dividend front end is selected with DIVIDER_BCD_IN_EN.
package divider_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StConv,
        StDiv,
        StDone
    } state_e;

    function automatic int unsigned dw(input int unsigned n);
        return 2 * n;
    endfunction

    function automatic int unsigned bcdw(input int unsigned n);
        return ((2 * n) / 3 + 1) * 4;
    endfunction

    localparam logic [3:0] BcdDigitMax = 4'd9;
    localparam logic [3:0] BcdAdjMin   = 4'd8;
    localparam logic [3:0] BcdAdj      = 4'd3;

endpackage

// File: rtl/n_bit_divider_if.sv
// Operand/result bundle for n_bit_divider; master drives requests, slave is the divider.
// DIVIDER_BCD_IN_EN swaps the binary dividend for a packed-BCD one plus an error flag.
interface n_bit_divider_if
    import divider_pkg::*;
#(
    parameter int unsigned N = 8
) ();
    localparam int unsigned DW = dw(N);

    logic          start;
`ifdef DIVIDER_BCD_IN_EN
    localparam int unsigned BCDW = bcdw(N);
    logic [BCDW-1:0] bcd_in;
    logic            bcd_err;
`else
    logic [DW-1:0] dividend;
`endif
    logic [N-1:0]  divisor;
    logic [DW-1:0] quotient;
    logic [N-1:0]  remainder;
    logic          finish;
    logic          div_by_zero;

    modport master (
        output start,
        output divisor,
`ifdef DIVIDER_BCD_IN_EN
        output bcd_in,
        input  bcd_err,
`else
        output dividend,
`endif
        input  quotient,
        input  remainder,
        input  finish,
        input  div_by_zero
    );

    modport slave (
        input  start,
        input  divisor,
`ifdef DIVIDER_BCD_IN_EN
        input  bcd_in,
        output bcd_err,
`else
        input  dividend,
`endif
        output quotient,
        output remainder,
        output finish,
        output div_by_zero
    );

endinterface

// File: rtl/bcd_to_bin_conv.sv
// Packed-BCD to binary converter (reverse double dabble), one bit per clock.
// Only instantiated when DIVIDER_BCD_IN_EN is defined.
module bcd_to_bin_conv
    import divider_pkg::*;
#(
    parameter int unsigned BCDW = 24,
    parameter int unsigned DW   = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_i,
    input  logic [BCDW-1:0] bcd_i,
    output logic            done_o,
    output logic [DW-1:0]   bin_o,
    output logic            digit_err_o,
    output logic            overflow_o
);
    localparam int unsigned NDig = BCDW / 4;
    localparam int unsigned CntW = $clog2(BCDW + 1);

    logic [BCDW-1:0] bcd_q, bcd_d, bin_q, bin_d;
    logic [BCDW-1:0] sh_bcd, sh_bin, adj_bcd;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            derr_q, derr_d;
    logic            derr_in;

    always_comb begin
        {sh_bcd, sh_bin} = {bcd_q, bin_q} >> 1;
        adj_bcd = sh_bcd;
        for (int i = 0; i < NDig; i++) begin
            if (sh_bcd[4*i +: 4] >= BcdAdjMin) adj_bcd[4*i +: 4] = sh_bcd[4*i +: 4] - BcdAdj;
        end
        derr_in = 1'b0;
        for (int i = 0; i < NDig; i++) begin
            if (bcd_i[4*i +: 4] > BcdDigitMax) derr_in = 1'b1;
        end
    end

    always_comb begin
        bcd_d  = bcd_q;
        bin_d  = bin_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        derr_d = derr_q;
        if (start_i) begin
            bcd_d  = bcd_i;
            bin_d  = '0;
            cnt_d  = CntW'(BCDW);
            busy_d = 1'b1;
            derr_d = derr_in;
        end else if (busy_q) begin
            bcd_d = adj_bcd;
            bin_d = sh_bin;
            cnt_d = cnt_q - CntW'(1);
            if (cnt_q == CntW'(1)) busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bcd_q  <= '0;
            bin_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            derr_q <= 1'b0;
        end else begin
            bcd_q  <= bcd_d;
            bin_q  <= bin_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            derr_q <= derr_d;
        end
    end

    // done marks the cycle whose edge performs the final shift; bin_o is that post-shift value.
    assign done_o      = busy_q && (cnt_q == CntW'(1));
    assign bin_o       = sh_bin[DW-1:0];
    assign overflow_o  = |sh_bin[BCDW-1:DW];
    assign digit_err_o = derr_q;

endmodule

// File: rtl/n_bit_divider.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor, one quotient bit per clock.
// Define DIVIDER_BCD_IN_EN to take the dividend as packed BCD through a CONV stage.
module n_bit_divider
    import divider_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic           clk,
    input  logic           reset,
    n_bit_divider_if.slave bus
);
    localparam int unsigned DW   = dw(N);
    localparam int unsigned CntW = $clog2(DW + 1);

    state_e          state_q, state_d;
    logic [DW-1:0]   dvd_q, dvd_d, quotient_q, quotient_d;
    logic [N-1:0]    rem_q, rem_d, dsr_q, dsr_d, remainder_q, remainder_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            finish_q, finish_d, dbz_q, dbz_d;
    logic            load;
    logic [N:0]      trial;
    logic            fits;
    logic [DW-1:0]   step_q;
    logic [N-1:0]    step_rem;

`ifdef DIVIDER_BCD_IN_EN
    localparam int unsigned BCDW = bcdw(N);
    logic          bcd_err_q, bcd_err_d;
    logic          conv_done, conv_derr, conv_ovf;
    logic [DW-1:0] conv_bin;

    bcd_to_bin_conv #(
        .BCDW(BCDW),
        .DW  (DW)
    ) u_conv (
        .clk        (clk),
        .reset      (reset),
        .start_i    (load),
        .bcd_i      (bus.bcd_in),
        .done_o     (conv_done),
        .bin_o      (conv_bin),
        .digit_err_o(conv_derr),
        .overflow_o (conv_ovf)
    );
`endif

    assign load = bus.start && (state_q == StIdle || state_q == StDone);

    // Low N bits suffice for the subtraction: when it fits the result is below the divisor.
    always_comb begin
        trial    = {rem_q, dvd_q[DW-1]};
        fits     = trial >= {1'b0, dsr_q};
        step_rem = fits ? (trial[N-1:0] - dsr_q) : trial[N-1:0];
        step_q   = {dvd_q[DW-2:0], fits};
    end

    always_comb begin
        state_d     = state_q;
        dvd_d       = dvd_q;
        rem_d       = rem_q;
        dsr_d       = dsr_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        finish_d    = finish_q;
        dbz_d       = dbz_q;
`ifdef DIVIDER_BCD_IN_EN
        bcd_err_d   = bcd_err_q;
`endif
        case (state_q)
            StIdle, StDone: begin
                if (load) begin
                    dsr_d       = bus.divisor;
                    rem_d       = '0;
                    cnt_d       = CntW'(DW);
                    quotient_d  = '0;
                    remainder_d = '0;
                    finish_d    = 1'b0;
                    dbz_d       = 1'b0;
`ifdef DIVIDER_BCD_IN_EN
                    bcd_err_d   = 1'b0;
                    state_d     = StConv;
`else
                    dvd_d       = bus.dividend;
                    state_d     = StDiv;
`endif
                end
            end
`ifdef DIVIDER_BCD_IN_EN
            StConv: begin
                if (conv_done) begin
                    if (conv_derr || conv_ovf) begin
                        bcd_err_d = 1'b1;
                        finish_d  = 1'b1;
                        state_d   = StDone;
                    end else begin
                        dvd_d   = conv_bin;
                        state_d = StDiv;
                    end
                end
            end
`endif
            StDiv: begin
                if (dsr_q == '0) begin
                    quotient_d  = '1;
                    remainder_d = '0;
                    dbz_d       = 1'b1;
                    finish_d    = 1'b1;
                    state_d     = StDone;
                end else begin
                    dvd_d = step_q;
                    rem_d = step_rem;
                    cnt_d = cnt_q - CntW'(1);
                    if (cnt_q == CntW'(1)) begin
                        quotient_d  = step_q;
                        remainder_d = step_rem;
                        finish_d    = 1'b1;
                        state_d     = StDone;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            dvd_q       <= '0;
            rem_q       <= '0;
            dsr_q       <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            finish_q    <= 1'b0;
            dbz_q       <= 1'b0;
`ifdef DIVIDER_BCD_IN_EN
            bcd_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            dvd_q       <= dvd_d;
            rem_q       <= rem_d;
            dsr_q       <= dsr_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            finish_q    <= finish_d;
            dbz_q       <= dbz_d;
`ifdef DIVIDER_BCD_IN_EN
            bcd_err_q   <= bcd_err_d;
`endif
        end
    end

    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.finish      = finish_q;
    assign bus.div_by_zero = dbz_q;
`ifdef DIVIDER_BCD_IN_EN
    assign bus.bcd_err     = bcd_err_q;
`endif

endmodule

// File: tb/tb_n_bit_divider.sv
// Self-checking bench for n_bit_divider at N=8; follows DIVIDER_BCD_IN_EN when defined.
module tb_n_bit_divider;
    localparam int unsigned N     = 8;
    localparam int unsigned DW    = 16;
    localparam int unsigned BCDW  = 24;
`ifdef DIVIDER_BCD_IN_EN
    localparam int          ConvLat = BCDW;
`else
    localparam int          ConvLat = 0;
`endif
    localparam int          Bound = 200;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    n_bit_divider_if #(.N(N)) bus ();

    n_bit_divider #(.N(N)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

`ifdef DIVIDER_BCD_IN_EN
    function automatic logic [23:0] to_bcd(input int unsigned v);
        logic [23:0] b;
        int unsigned t;
        b = '0;
        t = v;
        for (int i = 0; i < 6; i++) begin
            b[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return b;
    endfunction
`endif

    task automatic drive(input logic [15:0] dvd, input logic [7:0] dsr);
`ifdef DIVIDER_BCD_IN_EN
        bus.bcd_in = to_bcd(dvd);
`else
        bus.dividend = dvd;
`endif
        bus.divisor = dsr;
    endtask

    // Ends #1 after the load edge; start left high when hold is set.
    task automatic start_op(input logic [15:0] dvd, input logic [7:0] dsr, input bit hold);
        @(negedge clk);
        drive(dvd, dsr);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) bus.start = 1'b0;
    endtask

    // Called #1 after a load edge; poke rewrites operands to 5/9 mid-division.
    task automatic wait_check(input string tag, input logic [15:0] dvd, input logic [7:0] dsr,
                              input bit poke);
        logic [15:0] eq;
        logic [7:0]  er;
        logic        edbz;
        int          elat;
        int          cyc;
        if (dsr == 0) begin
            eq = 16'hFFFF; er = 8'd0; edbz = 1'b1; elat = ConvLat + 1;
        end else begin
            eq = 16'(int'(dvd) / int'(dsr));
            er = 8'(int'(dvd) % int'(dsr));
            edbz = 1'b0; elat = ConvLat + int'(DW);
        end
        cyc = 0;
        while (bus.finish !== 1'b1 && cyc < Bound) begin
            if (cyc == 0) begin
                check({tag, " cleared quotient"}, 32'(bus.quotient), 32'd0);
                check({tag, " cleared remainder"}, 32'(bus.remainder), 32'd0);
            end
            if (poke && cyc == ConvLat + 4) drive(16'd5, 8'd9);
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, " latency"}, 32'(cyc), 32'(elat));
        check({tag, " quotient"}, 32'(bus.quotient), 32'(eq));
        check({tag, " remainder"}, 32'(bus.remainder), 32'(er));
        check({tag, " div_by_zero"}, 32'(bus.div_by_zero), 32'(edbz));
`ifdef DIVIDER_BCD_IN_EN
        check({tag, " bcd_err"}, 32'(bus.bcd_err), 32'd0);
`endif
    endtask

`ifdef DIVIDER_BCD_IN_EN
    task automatic bcd_err_op(input string tag, input logic [23:0] raw);
        int cyc;
        @(negedge clk);
        bus.bcd_in  = raw;
        bus.divisor = 8'd123;
        bus.start   = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        cyc = 0;
        while (bus.finish !== 1'b1 && cyc < Bound) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, " finish"}, 32'(bus.finish), 32'd1);
        check({tag, " bcd_err"}, 32'(bus.bcd_err), 32'd1);
        check({tag, " quotient"}, 32'(bus.quotient), 32'd0);
        check({tag, " remainder"}, 32'(bus.remainder), 32'd0);
        check({tag, " div_by_zero"}, 32'(bus.div_by_zero), 32'd0);
    endtask
`endif

    initial begin
        logic [15:0] rd;
        logic [7:0]  rs;

        reset     = 1'b1;
        bus.start = 1'b0;
        drive(16'd0, 8'd0);
        repeat (2) @(posedge clk);
        #1;
        check("reset finish", 32'(bus.finish), 32'd0);
        check("reset quotient", 32'(bus.quotient), 32'd0);
        check("reset remainder", 32'(bus.remainder), 32'd0);
        check("reset div_by_zero", 32'(bus.div_by_zero), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        start_op(16'd24600, 8'd123, 1'b0);
        wait_check("24600/123", 16'd24600, 8'd123, 1'b0);
        start_op(16'd24650, 8'd123, 1'b0);
        wait_check("24650/123", 16'd24650, 8'd123, 1'b0);
        start_op(16'd65535, 8'd1, 1'b0);
        wait_check("65535/1", 16'd65535, 8'd1, 1'b0);
        start_op(16'd65535, 8'd255, 1'b0);
        wait_check("65535/255", 16'd65535, 8'd255, 1'b0);
        start_op(16'd5, 8'd9, 1'b0);
        wait_check("5/9", 16'd5, 8'd9, 1'b0);
        start_op(16'd1234, 8'd0, 1'b0);
        wait_check("1234/0", 16'd1234, 8'd0, 1'b0);

        // Asynchronous reset while DONE holds nonzero results.
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("async rst finish", 32'(bus.finish), 32'd0);
        check("async rst quotient", 32'(bus.quotient), 32'd0);
        check("async rst div_by_zero", 32'(bus.div_by_zero), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Reset mid-division, then the block must idle until the next start.
        start_op(16'd65535, 8'd3, 1'b0);
        repeat (ConvLat + 5) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("mid rst finish", 32'(bus.finish), 32'd0);
        check("mid rst quotient", 32'(bus.quotient), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (ConvLat + 20) @(posedge clk);
        #1;
        check("idle after rst finish", 32'(bus.finish), 32'd0);
        start_op(16'd24650, 8'd123, 1'b0);
        wait_check("post rst 24650/123", 16'd24650, 8'd123, 1'b0);

        // Start held high through the op with operands changed mid-division.
        start_op(16'd24650, 8'd123, 1'b1);
        wait_check("held start", 16'd24650, 8'd123, 1'b1);
        @(posedge clk);
        #1;
        check("b2b finish low", 32'(bus.finish), 32'd0);
        bus.start = 1'b0;
        wait_check("b2b 5/9", 16'd5, 8'd9, 1'b0);

        for (int i = 0; i < 20; i++) begin
            rd = 16'($urandom_range(0, 65535));
            rs = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            start_op(rd, rs, 1'b0);
            wait_check("random", rd, rs, 1'b0);
        end

`ifdef DIVIDER_BCD_IN_EN
        bcd_err_op("bcd digit", 24'h0A0000);
        bcd_err_op("bcd overflow", 24'h099999);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
